// File: rtl/grf_sb_if.sv
// grf_sb_if: register-file / scoreboard bus between decode/write-back and grf_sb.
//   master : drives read addresses, write-back (we/wa/wd) and issue (iss_en/iss_addr)
//   slave  : returns read data, per-port pending flags, iss_rdy, busy_any, err
interface grf_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pend;
   logic                     we;
   logic [ADDR_W-1:0]        wa;
   logic [DATA_W-1:0]        wd;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_rdy;
   logic                     busy_any;
   logic                     err;

   modport master (
      output rd_addr, we, wa, wd, iss_en, iss_addr,
      input  rd_data, rd_pend, iss_rdy, busy_any, err
   );

   modport slave (
      input  rd_addr, we, wa, wd, iss_en, iss_addr,
      output rd_data, rd_pend, iss_rdy, busy_any, err
   );
endinterface

// File: rtl/grf_sb.sv
// grf_sb: general register file with per-register write-pending scoreboard.
//   clk      : rising-edge clock for all state
//   reset    : synchronous active-high reset (clears registers, counters, err)
//   bus      : grf_sb_if slave modport
//              rd_addr/rd_data/rd_pend : NUM_RD combinational read ports with
//                                        write-back bypass and stall flag
//              we/wa/wd                : write-back port, retires one pending write
//              iss_en/iss_addr/iss_rdy : issue port, marks one pending write
//              busy_any                : any counter nonzero (registered state)
//              err                     : sticky protocol-error flag
module grf_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 1
) (
   input logic   clk,
   input logic   reset,
   grf_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_cnt [DEPTH];
   logic              r_err;

   logic                     w_wr_ok;
   logic                     w_iss_rdy;
   logic                     w_inc;
   logic                     w_dec;
   logic                     w_busy;
   logic [NUM_RD*DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]        w_rd_pend;

   function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign w_wr_ok   = bus.we && !f_is_zero(bus.wa);
   assign w_iss_rdy = f_is_zero(bus.iss_addr) || (r_cnt[bus.iss_addr] != CNT_MAX);
   assign w_inc     = bus.iss_en && w_iss_rdy && !f_is_zero(bus.iss_addr);
   // Underflow guard: a write with nothing pending is flagged, not counted.
   assign w_dec     = w_wr_ok && (r_cnt[bus.wa] != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
            r_cnt[i] <= '0;
         end
         r_err <= 1'b0;
      end else begin
         if (w_wr_ok)
            r_mem[bus.wa] <= bus.wd;
         // Inc and dec on the same register cancel; otherwise independent.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_inc && (bus.iss_addr == ADDR_W'(i)) && !(w_dec && (bus.wa == ADDR_W'(i))))
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            else if (w_dec && (bus.wa == ADDR_W'(i)) && !(w_inc && (bus.iss_addr == ADDR_W'(i))))
               r_cnt[i] <= r_cnt[i] - CNT_ONE;
         end
         if ((bus.iss_en && !w_iss_rdy) || (w_wr_ok && (r_cnt[bus.wa] == '0)))
            r_err <= 1'b1;
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      logic              hit;
      w_rd_data = '0;
      w_rd_pend = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         a   = bus.rd_addr[p*ADDR_W +: ADDR_W];
         hit = bus.we && (bus.wa == a);
         if (!f_is_zero(a)) begin
            w_rd_data[p*DATA_W +: DATA_W] = hit ? bus.wd : r_mem[a];
            // The last outstanding write being bypassed now clears the stall.
            w_rd_pend[p] = (r_cnt[a] != '0) && !(hit && (r_cnt[a] == CNT_ONE));
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
         w_busy = w_busy | (r_cnt[i] != '0);
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_pend  = w_rd_pend;
   assign bus.iss_rdy  = w_iss_rdy;
   assign bus.busy_any = w_busy;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed-vector bench for grf_sb (default parameters).
module tb_grf_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   grf_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   grf_sb #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(2), .ZERO_REG(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
      bus.iss_en = 1'b0; bus.iss_addr = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [DW-1:0] rd0();
      return bus.rd_data[DW-1:0];
   endfunction
   function automatic logic [DW-1:0] rd1();
      return bus.rd_data[2*DW-1:DW];
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      bus.rd_addr = '0;
      idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // 1: reset state on every address
      for (int a = 0; a < 32; a++) begin
         bus.rd_addr = {AW'(a), AW'(a)};
         #1;
         chk("rst_data", bus.rd_data, 64'h0);
         chk("rst_pend", 64'(bus.rd_pend), 64'h0);
      end
      chk("rst_busy", 64'(bus.busy_any), 64'h0);
      chk("rst_err", 64'(bus.err), 64'h0);
      chk("rst_rdy", 64'(bus.iss_rdy), 64'h1);

      // 2: bypass, array read, zero register
      bus.rd_addr = {AW'(0), AW'(5)};
      bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1234_5678;
      #1;
      chk("byp_r5", 64'(rd0()), 64'h1234_5678);
      tick();
      idle();
      #1;
      chk("arr_r5", 64'(rd0()), 64'h1234_5678);
      chk("err_wr_nopend", 64'(bus.err), 64'h1);
      bus.rd_addr = {AW'(5), AW'(0)};
      bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFF_FFFF;
      #1;
      chk("r0_byp", 64'(rd0()), 64'h0);
      tick();
      idle();
      #1;
      chk("r0_arr", 64'(rd0()), 64'h0);
      chk("r5_p1", 64'(rd1()), 64'h1234_5678);

      // 3: single issue / retire on r7, zero-reg issue ignored
      do_reset();
      bus.rd_addr = {AW'(7), AW'(0)};
      bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
      #1;
      chk("iss_prepend", 64'(bus.rd_pend), 64'h0);
      tick();
      bus.iss_addr = 5'd0;
      #1;
      chk("r0_iss_rdy", 64'(bus.iss_rdy), 64'h1);
      tick();
      idle();
      #1;
      chk("r7_pend", 64'(bus.rd_pend), 64'h2);
      chk("r7_busy", 64'(bus.busy_any), 64'h1);
      bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hA5;
      #1;
      chk("r7_wb_pend", 64'(bus.rd_pend), 64'h0);
      chk("r7_wb_data", 64'(rd1()), 64'hA5);
      chk("r7_wb_busy", 64'(bus.busy_any), 64'h1);
      tick();
      idle();
      #1;
      chk("r7_idle_busy", 64'(bus.busy_any), 64'h0);
      chk("r7_err", 64'(bus.err), 64'h0);

      // 4: saturate r3, then drain
      bus.rd_addr = {AW'(0), AW'(3)};
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("r3_rdy", 64'(bus.iss_rdy), 64'h1);
         tick();
      end
      #1;
      chk("r3_sat_rdy", 64'(bus.iss_rdy), 64'h0);
      chk("r3_sat_err", 64'(bus.err), 64'h0);
      tick();
      idle();
      bus.iss_addr = 5'd3;
      #1;
      chk("r3_ovr_err", 64'(bus.err), 64'h1);
      chk("r3_ovr_rdy", 64'(bus.iss_rdy), 64'h0);
      bus.we = 1'b1; bus.wa = 5'd3;
      for (int k = 0; k < 3; k++) begin
         bus.wd = 32'(k + 1);
         #1;
         chk("r3_drain_pend", 64'(bus.rd_pend[0]), (k == 2) ? 64'h0 : 64'h1);
         tick();
      end
      idle();
      bus.iss_addr = 5'd3;
      #1;
      chk("r3_done_pend", 64'(bus.rd_pend), 64'h0);
      chk("r3_done_busy", 64'(bus.busy_any), 64'h0);
      chk("r3_done_rdy", 64'(bus.iss_rdy), 64'h1);
      chk("r3_done_data", 64'(rd0()), 64'h3);

      // 5: simultaneous issue+retire on r9; write to idle r10
      do_reset();
      bus.rd_addr = {AW'(10), AW'(9)};
      bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
      tick();
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h99;
      #1;
      chk("r9_same_pend", 64'(bus.rd_pend[0]), 64'h0);
      tick();
      idle();
      #1;
      chk("r9_after_pend", 64'(bus.rd_pend[0]), 64'h1);
      chk("r9_data", 64'(rd0()), 64'h99);
      chk("r9_err", 64'(bus.err), 64'h0);
      bus.we = 1'b1; bus.wa = 5'd10; bus.wd = 32'hBEEF;
      tick();
      idle();
      #1;
      chk("r10_data", 64'(rd1()), 64'hBEEF);
      chk("r10_err", 64'(bus.err), 64'h1);
      chk("r10_pend", 64'(bus.rd_pend[1]), 64'h0);

      // 6: reset wins over in-flight state and a same-cycle write
      bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
      tick(); tick();
      idle();
      bus.rd_addr = {AW'(9), AW'(4)};
      #1;
      chk("r4_pre_pend", 64'(bus.rd_pend), 64'h3);
      bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h44;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      bus.iss_addr = 5'd4;
      #1;
      chk("r4_rst_data", 64'(rd0()), 64'h0);
      chk("r4_rst_pend", 64'(bus.rd_pend), 64'h0);
      chk("r4_rst_busy", 64'(bus.busy_any), 64'h0);
      chk("r4_rst_err", 64'(bus.err), 64'h0);
      chk("r4_rst_rdy", 64'(bus.iss_rdy), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
Parametrised general register file with an integrated write-pending scoreboard, for the pipelined CPU's decode/write-back stages.
- Provides NUM_RD combinational read ports with same-cycle write-back bypass.
- Provides one synchronous write port.
- Keeps a per-register counter of in-flight writes, so decode can stall on true RAW hazards without a separate hazard unit.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
CNT_W, 2, pending-counter width; max in-flight writes per register = 2**CNT_W-1
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never marked pending

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, combinational, same packing
rd_pend  output  NUM_RD  1 = port i value not yet available (stall)
we  input  1  write-back enable; also retires one pending write
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
iss_en  input  1  an instruction writing iss_addr is issued this cycle
iss_addr  input  ADDR_W  destination of issued instruction
iss_rdy  output  1  0 = counter for iss_addr saturated; issue must be held
busy_any  output  1  any register has a nonzero pending count
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (sync, highest priority):
  - All registers 0; all counters 0; err 0.
  - Writes and issues in the reset cycle are discarded.
  - After reset: rd_data all 0, rd_pend 0, busy_any 0, iss_rdy 1.
- "Zero reg" means ZERO_REG=1 and address 0.
- Write: at the edge, if we and wa is not the zero reg, mem[wa] <= wd. Zero reg write: no effect.
- Read port i (combinational, zero latency), in priority order:
  1. Zero reg -> 0.
  2. Else if we and wa==rd_addr_i -> wd (bypass).
  3. Else mem[rd_addr_i].
- Scoreboard counter cnt[r], updated at the edge:
  - inc = iss_en and iss_rdy and iss_addr not zero reg.
  - dec = we and wa not zero reg and cnt[wa]!=0.
  - Same register with inc and dec together: cnt unchanged.
  - Different registers: each updated independently.
- iss_rdy = !(cnt[iss_addr]==2**CNT_W-1), combinational. Zero reg is always ready.
- Protocol errors (each sets err; err stays 1 until reset):
  - iss_en while iss_rdy=0: issue ignored, cnt unchanged.
  - we to a non-zero reg with cnt[wa]==0: data still written, cnt stays 0.
- rd_pend_i = cnt[rd_addr_i]!=0, except:
  - Forced 0 if we, wa==rd_addr_i and cnt==1 (final pending write is bypassed this cycle).
  - Forced 0 for the zero reg.
  - An issue in the same cycle does not affect rd_pend; readers see pre-issue state.
- busy_any = OR over r of (cnt[r]!=0), from registered state; excludes same-cycle we/iss.
- Counter never wraps: saturation is blocked by iss_rdy, underflow is blocked by the dec condition.

Test Plan:
1. Reset, then read all 32 registers on both ports -> all 0, rd_pend=0, busy_any=0, err=0.
2. Write wd=0x1234_5678 to r5 with rd_addr0=5 in the same cycle -> rd_data0=0x1234_5678 that cycle (bypass); next cycle still 0x1234_5678 from the array. Write 0xFFFF_FFFF to r0 -> r0 reads 0.
3. Issue r7; next cycle rd_addr1=7 -> rd_pend1=1, busy_any=1. Then we to r7 with 0xA5 -> rd_pend1=0 and rd_data1=0xA5 in that cycle; busy_any=0 next cycle.
4. With CNT_W=2, issue r3 three times -> iss_rdy=0 when iss_addr=3. Fourth iss_en -> ignored, err=1. Then three we to r3 -> rd_pend stays 1 until the third write cycle; cnt reaches 0.
5. Issue r9 and we to r9 (cnt was 1) in the same cycle -> cnt stays 1, rd_pend=1 next cycle. we to r10 with cnt=0 -> data written, err=1.
6. Assert reset mid-flight with cnt[4]=2 and a simultaneous we to r4 -> next cycle r4 reads 0, cnt all 0, err=0.
